cpu_seq_cntrl: RTL and testbench
================================

Name: cpu_seq_cntrl

Overview:
- Multi-cycle control sequencer for the LEGv8 datapath.
- Replaces the single-cycle combinational decode with an FSM that steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives PC/IR write enables, ALU, memory and register-file controls, and handshakes with a variable-latency data memory.
- Supports a multi-cycle MUL unit.

Parameters:
- MUL_LAT, 4, number of EXEC cycles a MUL occupies (legal range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- inst  in  11  opcode field inst[31:21] from memory/IR; latched in FETCH.
- zero  in  1  ALU zero output (combinational, current EXEC).
- flag_n  in  1  stored N flag.
- flag_v  in  1  stored V flag.
- mem_ready  in  1  data-memory completion strobe.
- PCWrite  out  1  PC register enable.
- PCsrc  out  1  0 = PC+4, 1 = branch target (from latched instruction PC).
- IRWrite  out  1  instruction register enable.
- RegWrite, Reg2Loc, ALUsrc, SetFlags, MemWrite, MemRead, MemtoReg  out  1 each  datapath controls.
- ALUcntrl  out  3  ALU op: 000 pass B, 010 add, 011 sub, 100 mul, 101 lsl, 110 lsr.
- state  out  3  current FSM state, for debug.
- illegal  out  1  sticky undecodable-opcode flag.

Behaviour:
- Clock and reset: one clock domain, clk. reset is asynchronous and active-high.
- Reset:
  - state=IDLE, opcode register=0, mul counter=0, illegal=0.
  - All outputs are 0 while reset is high and in IDLE. Outputs never drive Z.
- States: IDLE=000, FETCH=001, DECODE=010, EXEC=011, MEM=100, WB=101, TRAP=111.
  - IDLE goes to FETCH on the first clock after reset deasserts.
- Outputs are Moore: a function of state and latched opcode only; zero/flag_n/flag_v affect PCWrite in EXEC only.
- FETCH:
  - IRWrite=1, PCWrite=1, PCsrc=0.
  - Latch inst into the opcode register.
  - Next state DECODE.
- DECODE:
  - Classify the latched opcode:
    - ADDI 1001000100x
    - ADDS 10101011000
    - SUBS 11101011000
    - MUL 10011011000
    - LSL 11010011011
    - LSR 11010011010
    - B 000101xxxxx
    - CBZ 10110100xxx
    - B.LT 01010100xxx
    - LDUR 11111000010
    - STUR 11111000000
  - Unmatched opcode goes to TRAP; otherwise EXEC.
- Static controls, held constant from DECODE through the last state of the instruction:
  - ALUcntrl: ADDI/ADDS/LDUR/STUR=010, SUBS=011, MUL=100, LSL=101, LSR=110, CBZ=000, B/B.LT=000.
  - ALUsrc=1 for ADDI/LSL/LSR/LDUR/STUR.
  - Reg2Loc=1 for CBZ/LDUR/STUR.
  - All unused controls are 0.
- EXEC:
  - MUL: stays MUL_LAT cycles. The counter counts 0..MUL_LAT-1, then goes to WB and the counter clears.
  - SetFlags=1 for exactly one cycle (the EXEC cycle) for ADDS/SUBS.
  - Branch handling, PCsrc=1 when taken, then next state FETCH:
    - B: PCWrite=1.
    - CBZ: PCWrite=zero.
    - B.LT: PCWrite=(flag_n!=flag_v).
  - LDUR/STUR go to MEM. All ALU ops go to WB.
- MEM:
  - MemRead=1 (LDUR) or MemWrite=1 (STUR), held until the cycle mem_ready=1.
  - On that cycle: LDUR goes to WB, STUR goes to FETCH.
  - mem_ready outside MEM is ignored.
- WB:
  - RegWrite=1 for one cycle; MemtoReg=1 for LDUR.
  - Next state FETCH.
- TRAP:
  - illegal=1, all enables 0, remains until reset.
- Cycle counts:
  - ALU ops: 4.
  - MUL: 3+MUL_LAT.
  - Branches: 3.
  - STUR: 4+wait cycles.
  - LDUR: 5+wait cycles.
- Reset mid-operation: immediate return to IDLE; a pending memory access is abandoned (MemRead/MemWrite drop asynchronously).

Optional Feature:
- Macro: CPU_SEQ_CNTRL_PERF_EN.
- When defined:
  - Adds outputs retired_cnt[31:0] and stall_cnt[31:0], both reset to 0.
  - retired_cnt increments on each transition into FETCH from EXEC/MEM/WB.
  - stall_cnt increments on each MEM cycle with mem_ready=0 and each MUL EXEC cycle beyond the first.
  - Both counters wrap at 2^32.
- When undefined: ports absent, no counter logic.

Test Plan:
- Reset: assert reset mid-EXEC -> state=000 and all outputs 0 immediately; first posedge after release -> FETCH with IRWrite=1, PCWrite=1.
- ADDS (10101011000) -> FETCH, DECODE, EXEC (SetFlags=1, ALUcntrl=010), WB (RegWrite=1), FETCH; exactly 4 cycles.
- MUL with MUL_LAT=4 -> EXEC held 4 cycles with ALUcntrl=100, then WB; 7 cycles total.
- LDUR with mem_ready low 3 cycles -> MemRead=1 for 4 cycles, then WB with MemtoReg=1; STUR likewise with MemWrite=1, returning to FETCH without RegWrite.
- CBZ with zero=1 -> PCWrite=1, PCsrc=1 in EXEC; zero=0 -> PCWrite=0. B.LT with N=1, V=0 -> taken; N=1, V=1 -> not taken.
- Opcode 00000000000 -> TRAP, illegal=1 persists across 10 cycles, cleared only by reset.

Source files
------------

// File: rtl/cpu_seq_cntrl_if.sv
// Bus between the LEGv8 multi-cycle sequencer and the datapath it steers.
// The master side is the sequencer; the slave side is the datapath/memory.
interface cpu_seq_cntrl_if;
  logic [10:0] inst;
  logic        zero;
  logic        flag_n;
  logic        flag_v;
  logic        mem_ready;
  logic        PCWrite;
  logic        PCsrc;
  logic        IRWrite;
  logic        RegWrite;
  logic        Reg2Loc;
  logic        ALUsrc;
  logic        SetFlags;
  logic        MemWrite;
  logic        MemRead;
  logic        MemtoReg;
  logic [2:0]  ALUcntrl;
  logic [2:0]  state;
  logic        illegal;

  modport master (
    input  inst, zero, flag_n, flag_v, mem_ready,
    output PCWrite, PCsrc, IRWrite, RegWrite, Reg2Loc, ALUsrc, SetFlags,
           MemWrite, MemRead, MemtoReg, ALUcntrl, state, illegal
  );

  modport slave (
    output inst, zero, flag_n, flag_v, mem_ready,
    input  PCWrite, PCsrc, IRWrite, RegWrite, Reg2Loc, ALUsrc, SetFlags,
           MemWrite, MemRead, MemtoReg, ALUcntrl, state, illegal
  );
endinterface

// File: rtl/cpu_seq_cntrl.sv
// Multi-cycle LEGv8 control sequencer: FETCH/DECODE/EXEC/MEM/WB with a
// multi-cycle MUL and a variable-latency memory handshake.
// Optional performance counters are enabled by defining CPU_SEQ_CNTRL_PERF_EN.
module cpu_seq_cntrl #(
  parameter int MUL_LAT = 4
) (
  input  logic clk,
  input  logic reset,
  cpu_seq_cntrl_if.master bus
`ifdef CPU_SEQ_CNTRL_PERF_EN
  ,
  output logic [31:0] retired_cnt,
  output logic [31:0] stall_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    FETCH  = 3'b001,
    DECODE = 3'b010,
    EXEC   = 3'b011,
    MEM    = 3'b100,
    WB     = 3'b101,
    TRAP   = 3'b111
  } state_t;

  typedef enum logic [3:0] {
    K_BAD, K_ADDI, K_ADDS, K_SUBS, K_MUL, K_LSL, K_LSR,
    K_B, K_CBZ, K_BLT, K_LDUR, K_STUR
  } kind_t;

  localparam logic [3:0] MUL_LAST = 4'(MUL_LAT - 1);

  state_t      cur, nxt;
  logic [10:0] opcode;
  logic [3:0]  mul_cnt;
  kind_t       kind;
  logic        mul_last;
  logic        in_instr;
  logic [2:0]  alu_op;
  logic        alu_src;
  logic        reg2loc;

  always_comb begin
    kind = K_BAD;
    casez (opcode)
      11'b1001000100?: kind = K_ADDI;
      11'b10101011000: kind = K_ADDS;
      11'b11101011000: kind = K_SUBS;
      11'b10011011000: kind = K_MUL;
      11'b11010011011: kind = K_LSL;
      11'b11010011010: kind = K_LSR;
      11'b000101?????: kind = K_B;
      11'b10110100???: kind = K_CBZ;
      11'b01010100???: kind = K_BLT;
      11'b11111000010: kind = K_LDUR;
      11'b11111000000: kind = K_STUR;
      default:         kind = K_BAD;
    endcase
  end

  // Static per-instruction controls, valid from DECODE to the instruction's last state
  always_comb begin
    alu_op  = 3'b000;
    alu_src = 1'b0;
    reg2loc = 1'b0;
    case (kind)
      K_ADDI:  begin alu_op = 3'b010; alu_src = 1'b1; end
      K_ADDS:  alu_op = 3'b010;
      K_SUBS:  alu_op = 3'b011;
      K_MUL:   alu_op = 3'b100;
      K_LSL:   begin alu_op = 3'b101; alu_src = 1'b1; end
      K_LSR:   begin alu_op = 3'b110; alu_src = 1'b1; end
      K_CBZ:   reg2loc = 1'b1;
      K_LDUR,
      K_STUR:  begin alu_op = 3'b010; alu_src = 1'b1; reg2loc = 1'b1; end
      default: ;
    endcase
  end

  assign mul_last = (mul_cnt == MUL_LAST);
  assign in_instr = (cur == DECODE) || (cur == EXEC) || (cur == MEM) || (cur == WB);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur     <= IDLE;
      opcode  <= 11'd0;
      mul_cnt <= 4'd0;
    end else begin
      cur <= nxt;
      if (cur == FETCH) opcode <= bus.inst;
      if (cur == EXEC && kind == K_MUL) mul_cnt <= mul_last ? 4'd0 : mul_cnt + 4'd1;
      else                              mul_cnt <= 4'd0;
    end
  end

  always_comb begin
    nxt = cur;
    case (cur)
      IDLE:   nxt = FETCH;
      FETCH:  nxt = DECODE;
      DECODE: nxt = (kind == K_BAD) ? TRAP : EXEC;
      EXEC: begin
        case (kind)
          K_MUL:              nxt = mul_last ? WB : EXEC;
          K_B, K_CBZ, K_BLT:  nxt = FETCH;
          K_LDUR, K_STUR:     nxt = MEM;
          default:            nxt = WB;
        endcase
      end
      MEM:    if (bus.mem_ready) nxt = (kind == K_LDUR) ? WB : FETCH;
      WB:     nxt = FETCH;
      TRAP:   nxt = TRAP;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    logic taken;
    taken        = 1'b0;
    bus.PCWrite  = 1'b0;
    bus.PCsrc    = 1'b0;
    bus.IRWrite  = 1'b0;
    bus.RegWrite = 1'b0;
    bus.SetFlags = 1'b0;
    bus.MemWrite = 1'b0;
    bus.MemRead  = 1'b0;
    bus.MemtoReg = 1'b0;
    bus.ALUcntrl = in_instr ? alu_op  : 3'b000;
    bus.ALUsrc   = in_instr ? alu_src : 1'b0;
    bus.Reg2Loc  = in_instr ? reg2loc : 1'b0;
    bus.state    = cur;
    bus.illegal  = (cur == TRAP);
    case (cur)
      FETCH: begin
        bus.IRWrite = 1'b1;
        bus.PCWrite = 1'b1;
      end
      EXEC: begin
        case (kind)
          K_B:   taken = 1'b1;
          K_CBZ: taken = bus.zero;
          K_BLT: taken = (bus.flag_n != bus.flag_v);
          default: taken = 1'b0;
        endcase
        bus.PCWrite  = taken;
        bus.PCsrc    = taken;
        bus.SetFlags = (kind == K_ADDS) || (kind == K_SUBS);
      end
      MEM: begin
        bus.MemRead  = (kind == K_LDUR);
        bus.MemWrite = (kind == K_STUR);
      end
      WB: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = (kind == K_LDUR);
      end
      default: ;
    endcase
  end

`ifdef CPU_SEQ_CNTRL_PERF_EN
  // Retire on re-entry to FETCH from a working state; stalls are memory waits and extra MUL cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_cnt <= 32'd0;
      stall_cnt   <= 32'd0;
    end else begin
      if (nxt == FETCH && (cur == EXEC || cur == MEM || cur == WB))
        retired_cnt <= retired_cnt + 32'd1;
      if ((cur == MEM && !bus.mem_ready) ||
          (cur == EXEC && kind == K_MUL && mul_cnt != 4'd0))
        stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_seq_cntrl.sv
// Directed bench for cpu_seq_cntrl: expected per-cycle control vectors are
// queued as each step is driven and compared when the DUT state is sampled.
module tb_cpu_seq_cntrl;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  cpu_seq_cntrl_if bus();

`ifdef CPU_SEQ_CNTRL_PERF_EN
  logic [31:0] retired_cnt, stall_cnt;
  cpu_seq_cntrl #(.MUL_LAT(4)) dut (.clk(clk), .reset(reset), .bus(bus.master),
                                    .retired_cnt(retired_cnt), .stall_cnt(stall_cnt));
`else
  cpu_seq_cntrl #(.MUL_LAT(4)) dut (.clk(clk), .reset(reset), .bus(bus.master));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Control bit masks: {PCWrite,PCsrc,IRWrite,RegWrite,Reg2Loc,ALUsrc,SetFlags,MemWrite,MemRead,MemtoReg,illegal}
  localparam logic [10:0] PW  = 11'h400, PS = 11'h200, IR  = 11'h100, RW  = 11'h080;
  localparam logic [10:0] R2  = 11'h040, AS = 11'h020, SF  = 11'h010, MW  = 11'h008;
  localparam logic [10:0] MR  = 11'h004, MTR = 11'h002, ILL = 11'h001;

  logic [16:0] sb_q[$];
  string       tag_q[$];

  function automatic logic [16:0] ev(input logic [2:0] st, input logic [2:0] alu, input logic [10:0] b);
    return {st, alu, b};
  endfunction

  function automatic logic [16:0] obs();
    return {bus.state, bus.ALUcntrl, bus.PCWrite, bus.PCsrc, bus.IRWrite, bus.RegWrite,
            bus.Reg2Loc, bus.ALUsrc, bus.SetFlags, bus.MemWrite, bus.MemRead,
            bus.MemtoReg, bus.illegal};
  endfunction

  task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Queue the expectation, sample mid-cycle, then advance just past the next edge
  task automatic step(input string tag, input logic [16:0] e);
    logic [16:0] exp;
    string       t;
    sb_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    exp = sb_q.pop_front();
    t   = tag_q.pop_front();
    check(t, obs(), exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    bus.inst = 11'd0;
    bus.zero = 1'b0;
    bus.flag_n = 1'b0;
    bus.flag_v = 1'b0;
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    step("reset_idle", ev(3'd0, 3'd0, 11'd0));
    reset = 1'b0;
    step("idle_after_release", ev(3'd0, 3'd0, 11'd0));

    // ADDS: 4 cycles
    bus.inst = 11'b10101011000;
    step("adds_fetch",  ev(3'd1, 3'd0, PW | IR));
    step("adds_decode", ev(3'd2, 3'd2, 11'd0));
    step("adds_exec",   ev(3'd3, 3'd2, SF));
    step("adds_wb",     ev(3'd5, 3'd2, RW));

    // MUL: EXEC held MUL_LAT=4 cycles
    bus.inst = 11'b10011011000;
    step("mul_fetch",  ev(3'd1, 3'd0, PW | IR));
    step("mul_decode", ev(3'd2, 3'd4, 11'd0));
    for (int i = 0; i < 4; i++) step("mul_exec", ev(3'd3, 3'd4, 11'd0));
    step("mul_wb",     ev(3'd5, 3'd4, RW));

    // LDUR with three wait cycles
    bus.inst = 11'b11111000010;
    step("ldur_fetch",  ev(3'd1, 3'd0, PW | IR));
    step("ldur_decode", ev(3'd2, 3'd2, AS | R2));
    step("ldur_exec",   ev(3'd3, 3'd2, AS | R2));
    for (int i = 0; i < 3; i++) step("ldur_mem_wait", ev(3'd4, 3'd2, AS | R2 | MR));
    bus.mem_ready = 1'b1;
    step("ldur_mem_done", ev(3'd4, 3'd2, AS | R2 | MR));
    bus.mem_ready = 1'b0;
    step("ldur_wb",     ev(3'd5, 3'd2, AS | R2 | RW | MTR));

    // STUR: mem_ready high before MEM is ignored, then three waits
    bus.inst = 11'b11111000000;
    step("stur_fetch",  ev(3'd1, 3'd0, PW | IR));
    bus.mem_ready = 1'b1;
    step("stur_decode", ev(3'd2, 3'd2, AS | R2));
    step("stur_exec",   ev(3'd3, 3'd2, AS | R2));
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("stur_mem_wait", ev(3'd4, 3'd2, AS | R2 | MW));
    bus.mem_ready = 1'b1;
    step("stur_mem_done", ev(3'd4, 3'd2, AS | R2 | MW));
    bus.mem_ready = 1'b0;

    // CBZ taken / not taken
    bus.inst = 11'b10110100101;
    bus.zero = 1'b1;
    step("cbz_fetch",  ev(3'd1, 3'd0, PW | IR));
    step("cbz_decode", ev(3'd2, 3'd0, R2));
    step("cbz_taken",  ev(3'd3, 3'd0, R2 | PW | PS));
    bus.zero = 1'b0;
    step("cbz2_fetch", ev(3'd1, 3'd0, PW | IR));
    step("cbz2_decode", ev(3'd2, 3'd0, R2));
    step("cbz_not_taken", ev(3'd3, 3'd0, R2));

    // B.LT taken (N!=V) / not taken (N==V)
    bus.inst = 11'b01010100011;
    bus.flag_n = 1'b1;
    bus.flag_v = 1'b0;
    step("blt_fetch",  ev(3'd1, 3'd0, PW | IR));
    step("blt_decode", ev(3'd2, 3'd0, 11'd0));
    step("blt_taken",  ev(3'd3, 3'd0, PW | PS));
    bus.flag_v = 1'b1;
    step("blt2_fetch", ev(3'd1, 3'd0, PW | IR));
    step("blt2_decode", ev(3'd2, 3'd0, 11'd0));
    step("blt_not_taken", ev(3'd3, 3'd0, 11'd0));

    // Unconditional B
    bus.inst = 11'b00010111111;
    step("b_fetch",  ev(3'd1, 3'd0, PW | IR));
    step("b_decode", ev(3'd2, 3'd0, 11'd0));
    step("b_exec",   ev(3'd3, 3'd0, PW | PS));

    // ADDI (low bit don't-care), SUBS, LSL, LSR
    bus.inst = 11'b10010001001;
    step("addi_fetch", ev(3'd1, 3'd0, PW | IR));
    step("addi_decode", ev(3'd2, 3'd2, AS));
    step("addi_exec",  ev(3'd3, 3'd2, AS));
    step("addi_wb",    ev(3'd5, 3'd2, AS | RW));
    bus.inst = 11'b11101011000;
    step("subs_fetch", ev(3'd1, 3'd0, PW | IR));
    step("subs_decode", ev(3'd2, 3'd3, 11'd0));
    step("subs_exec",  ev(3'd3, 3'd3, SF));
    step("subs_wb",    ev(3'd5, 3'd3, RW));
    bus.inst = 11'b11010011011;
    step("lsl_fetch",  ev(3'd1, 3'd0, PW | IR));
    step("lsl_decode", ev(3'd2, 3'd5, AS));
    step("lsl_exec",   ev(3'd3, 3'd5, AS));
    step("lsl_wb",     ev(3'd5, 3'd5, AS | RW));
    bus.inst = 11'b11010011010;
    step("lsr_fetch",  ev(3'd1, 3'd0, PW | IR));
    step("lsr_decode", ev(3'd2, 3'd6, AS));
    step("lsr_exec",   ev(3'd3, 3'd6, AS));
    step("lsr_wb",     ev(3'd5, 3'd6, AS | RW));

    // Asynchronous reset while in EXEC
    bus.inst = 11'b10101011000;
    step("rexec_fetch",  ev(3'd1, 3'd0, PW | IR));
    step("rexec_decode", ev(3'd2, 3'd2, 11'd0));
    #2 reset = 1'b1;
    #1 check("reset_async_exec", obs(), ev(3'd0, 3'd0, 11'd0));
    step("reset_hold", ev(3'd0, 3'd0, 11'd0));
    reset = 1'b0;
    step("idle_release2", ev(3'd0, 3'd0, 11'd0));

    // Asynchronous reset while a load is waiting in MEM
    bus.inst = 11'b11111000010;
    step("rmem_fetch",  ev(3'd1, 3'd0, PW | IR));
    step("rmem_decode", ev(3'd2, 3'd2, AS | R2));
    step("rmem_exec",   ev(3'd3, 3'd2, AS | R2));
    step("rmem_wait",   ev(3'd4, 3'd2, AS | R2 | MR));
    #2 reset = 1'b1;
    #1 check("reset_async_mem", obs(), ev(3'd0, 3'd0, 11'd0));
    step("reset_hold2", ev(3'd0, 3'd0, 11'd0));
    reset = 1'b0;
    step("idle_release3", ev(3'd0, 3'd0, 11'd0));

    // Undecodable opcode traps and stays trapped
    bus.inst = 11'b00000000000;
    step("trap_fetch",  ev(3'd1, 3'd0, PW | IR));
    step("trap_decode", ev(3'd2, 3'd0, 11'd0));
    bus.inst = 11'b10101011000;
    for (int i = 0; i < 10; i++) step("trap_hold", ev(3'd7, 3'd0, ILL));
    reset = 1'b1;
    #1 check("trap_cleared", obs(), ev(3'd0, 3'd0, 11'd0));
    step("trap_reset_hold", ev(3'd0, 3'd0, 11'd0));
    reset = 1'b0;
    step("idle_release4", ev(3'd0, 3'd0, 11'd0));
    step("fetch_after_trap", ev(3'd1, 3'd0, PW | IR));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
